// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared codes and the W pipeline register control record
package y86_pkg;

  typedef enum logic [3:0] {
    SAOK = 4'h1,
    SHLT = 4'h2,
    SADR = 4'h3,
    SINS = 4'h4
  } stat_e;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  // Control half of the W register; the XLEN-wide data fields live beside it
  // so the datapath width stays a module parameter.
  typedef struct packed {
    logic [3:0] stat;
    logic [3:0] icode;
    logic [3:0] dstE;
    logic [3:0] dstM;
    logic       valid;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{stat: SAOK, icode: INOP, dstE: RNONE, dstM: RNONE, valid: 1'b0};

endpackage

// File: rtl/wb_pipe_reg.sv
// rtl/wb_pipe_reg.sv - W pipeline register with freeze, stall and bubble insertion
module wb_pipe_reg
  import y86_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            freeze,
  input  logic            stall,
  input  logic            bubble,
  input  w_reg_t          mCtl,
  input  logic [XLEN-1:0] mValE,
  input  logic [XLEN-1:0] mValM,
  output w_reg_t          wCtl,
  output logic [XLEN-1:0] wValE,
  output logic [XLEN-1:0] wValM
);

  // Freeze (halt) and stall both hold; bubble replaces contents with a NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wCtl  <= W_BUBBLE;
      wValE <= '0;
      wValM <= '0;
    end else if (freeze || stall) begin
      wCtl  <= wCtl;
      wValE <= wValE;
      wValM <= wValM;
    end else if (bubble) begin
      wCtl  <= W_BUBBLE;
      wValE <= '0;
      wValM <= '0;
    end else begin
      wCtl  <= mCtl;
      wValE <= mValE;
      wValM <= mValM;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - Y86-64 writeback stage; WB_PERF_CNT_EN adds retire/bubble counters
module wb_stage
  import y86_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             W_stall,
  input  logic             W_bubble,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       m_icode,
  input  logic [XLEN-1:0]  m_valE,
  input  logic [XLEN-1:0]  m_valM,
  input  logic [3:0]       m_dstE,
  input  logic [3:0]       m_dstM,
  output logic [3:0]       W_stat,
  output logic [3:0]       W_icode,
  output logic [XLEN-1:0]  W_valE,
  output logic [XLEN-1:0]  W_valM,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic [3:0]       dstE,
  output logic [XLEN-1:0]  E,
  output logic [3:0]       dstM,
  output logic [XLEN-1:0]  M,
  output logic [3:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] bubbles
);

  w_reg_t     mCtl;
  w_reg_t     wCtl;
  logic       haltedQ;
  logic [3:0] haltStatQ;
  logic       haltNow;
  logic       gateWrite;
  logic       sameDst;

  assign mCtl = '{stat: m_stat, icode: m_icode, dstE: m_dstE, dstM: m_dstM, valid: 1'b1};

  // A valid non-SAOK instruction sitting in W halts the machine on this edge;
  // W is frozen on the same edge so the faulting instruction stays visible.
  assign haltNow = wCtl.valid && (wCtl.stat != SAOK) && !haltedQ;

  wb_pipe_reg #(.XLEN(XLEN)) uPipeReg (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (haltedQ || haltNow),
    .stall  (W_stall),
    .bubble (W_bubble),
    .mCtl   (mCtl),
    .mValE  (m_valE),
    .mValM  (m_valM),
    .wCtl   (wCtl),
    .wValE  (W_valE),
    .wValM  (W_valM)
  );

  assign W_stat  = wCtl.stat;
  assign W_icode = wCtl.icode;
  assign W_dstE  = wCtl.dstE;
  assign W_dstM  = wCtl.dstM;

  // Faulting or halted instructions never write; on a shared destination M wins (popq %rsp).
  assign gateWrite = haltedQ || (wCtl.stat != SAOK);
  assign sameDst   = (wCtl.dstE == wCtl.dstM) && (wCtl.dstM != RNONE);
  assign dstE      = (gateWrite || sameDst) ? RNONE : wCtl.dstE;
  assign dstM      = gateWrite ? RNONE : wCtl.dstM;
  assign E         = W_valE;
  assign M         = W_valM;

  // Sticky halt flag and the status code that caused it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      haltedQ   <= 1'b0;
      haltStatQ <= SAOK;
    end else if (haltNow) begin
      haltedQ   <= 1'b1;
      haltStatQ <= wCtl.stat;
    end
  end

  assign halted   = haltedQ;
  assign cpu_stat = haltedQ ? haltStatQ : wCtl.stat;

`ifdef WB_PERF_CNT_EN
  logic [CNT_W-1:0] retiredQ;
  logic [CNT_W-1:0] bubblesQ;

  // Free-running wrap-around counters of retired instructions and bubble cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retiredQ <= '0;
      bubblesQ <= '0;
    end else begin
      if (wCtl.valid && (wCtl.stat == SAOK) && !haltedQ && !W_stall)
        retiredQ <= retiredQ + CNT_W'(1);
      if (!wCtl.valid && !haltedQ)
        bubblesQ <= bubblesQ + CNT_W'(1);
    end
  end

  assign retired = retiredQ;
  assign bubbles = bubblesQ;
`else
  assign retired = '0;
  assign bubbles = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage against a behavioural model
module tb_wb_stage;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;
  localparam logic [3:0] F = 4'hF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             W_stall = 1'b0;
  logic             W_bubble = 1'b0;
  logic [3:0]       m_stat = 4'h1;
  logic [3:0]       m_icode = 4'h1;
  logic [XLEN-1:0]  m_valE = '0;
  logic [XLEN-1:0]  m_valM = '0;
  logic [3:0]       m_dstE = 4'hF;
  logic [3:0]       m_dstM = 4'hF;
  logic [3:0]       W_stat, W_icode, W_dstE, W_dstM, dstE, dstM, cpu_stat;
  logic [XLEN-1:0]  W_valE, W_valM, E, M;
  logic             halted;
  logic [CNT_W-1:0] retired, bubbles;

  wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .W_stall(W_stall), .W_bubble(W_bubble),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .dstE(dstE), .E(E), .dstM(dstM), .M(M),
    .cpu_stat(cpu_stat), .halted(halted), .retired(retired), .bubbles(bubbles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: the instruction occupying W plus machine-level status.
  logic            refValid, refHalted;
  logic [3:0]      refStat, refIcode, refDstE, refDstM, refHaltCode;
  logic [XLEN-1:0] refValE, refValM;
  logic [31:0]     refRet, refBub;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refLoadNop();
    refValid = 1'b0; refStat = 4'h1; refIcode = 4'h1;
    refValE = '0; refValM = '0; refDstE = F; refDstM = F;
  endtask

  task automatic refReset();
    refLoadNop();
    refHalted = 1'b0; refHaltCode = 4'h1; refRet = 0; refBub = 0;
  endtask

  // One clock edge of the machine, judged from inputs present at the edge.
  task automatic refEdge();
    logic faulting;
    if (!rst_n) begin
      refReset();
      return;
    end
    faulting = refValid && (refStat != 4'h1) && !refHalted;
    if (refValid && refStat == 4'h1 && !refHalted && !W_stall) refRet = refRet + 1;
    if (!refValid && !refHalted) refBub = refBub + 1;
    if (faulting) begin
      refHalted = 1'b1;
      refHaltCode = refStat;
    end else if (!refHalted && !W_stall) begin
      if (W_bubble) refLoadNop();
      else begin
        refValid = 1'b1; refStat = m_stat; refIcode = m_icode;
        refValE = m_valE; refValM = m_valM; refDstE = m_dstE; refDstM = m_dstM;
      end
    end
  endtask

  task automatic checkAll(input string ph);
    logic       noWrite;
    logic [3:0] expDstE, expDstM, expCpu;
    logic [31:0] expRet, expBub;
    noWrite = refHalted || (refStat != 4'h1);
    expDstM = noWrite ? F : refDstM;
    expDstE = (noWrite || refDstE == refDstM) ? F : refDstE;
    expCpu  = refHalted ? refHaltCode : refStat;
`ifdef WB_PERF_CNT_EN
    expRet = refRet; expBub = refBub;
`else
    expRet = 0; expBub = 0;
`endif
    chk({ph, ".W_stat"},  64'(W_stat),  64'(refStat));
    chk({ph, ".W_icode"}, 64'(W_icode), 64'(refIcode));
    chk({ph, ".W_valE"},  W_valE, refValE);
    chk({ph, ".W_valM"},  W_valM, refValM);
    chk({ph, ".W_dstE"},  64'(W_dstE),  64'(refDstE));
    chk({ph, ".W_dstM"},  64'(W_dstM),  64'(refDstM));
    chk({ph, ".dstE"},    64'(dstE),    64'(expDstE));
    chk({ph, ".dstM"},    64'(dstM),    64'(expDstM));
    chk({ph, ".E"},       E, refValE);
    chk({ph, ".M"},       M, refValM);
    chk({ph, ".cpu_stat"}, 64'(cpu_stat), 64'(expCpu));
    chk({ph, ".halted"},  64'(halted),  64'(refHalted));
    chk({ph, ".retired"}, 64'(retired), 64'(expRet));
    chk({ph, ".bubbles"}, 64'(bubbles), 64'(expBub));
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    refEdge();
    #1;
    checkAll(ph);
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] ic, input logic [63:0] ve,
                       input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
    m_stat = st; m_icode = ic; m_valE = ve; m_valM = vm; m_dstE = de; m_dstM = dm;
  endtask

  // Reset asserted between edges must act immediately; release lands on a negedge.
  task automatic asyncReset(input string ph);
    #2;
    rst_n = 1'b0;
    #1;
    refReset();
    checkAll(ph);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    refReset();

    // 1: reset, then an asynchronous reset mid-cycle after some activity
    cycle("rst0");
    cycle("rst1");
    @(negedge clk); rst_n = 1'b1;
    drive(4'h1, 4'h6, 64'h11, 64'h0, 4'h1, F);
    cycle("pre1");
    drive(4'h1, 4'h6, 64'h22, 64'h0, 4'h2, F);
    cycle("pre2");
    asyncReset("arst");
    chk("arst.W_dstE", 64'(W_dstE), 64'hF);
    chk("arst.W_dstM", 64'(W_dstM), 64'hF);
    chk("arst.cpu_stat", 64'(cpu_stat), 64'h1);
    chk("arst.halted", 64'(halted), 64'h0);
    chk("arst.retired", 64'(retired), 64'h0);

    // 2: irmovq writes E
    drive(4'h1, 4'h3, 64'd42, 64'h0, 4'h3, F);
    cycle("irmovq");
    chk("irmovq.dstE", 64'(dstE), 64'h3);
    chk("irmovq.E", E, 64'd42);
    chk("irmovq.dstM", 64'(dstM), 64'hF);
    drive(4'h1, 4'h1, 64'h0, 64'h0, F, F);
    cycle("irmovq_ret");

    // 3: popq %rsp, M wins
    drive(4'h1, 4'hB, 64'h100, 64'h200, 4'h4, 4'h4);
    cycle("popq");
    chk("popq.dstE", 64'(dstE), 64'hF);
    chk("popq.dstM", 64'(dstM), 64'h4);
    chk("popq.M", M, 64'h200);

    // 4: stall holds, bubble clears, stall+bubble holds
    drive(4'h1, 4'h6, 64'h77, 64'h0, 4'h2, F);
    cycle("ld2");
    W_stall = 1'b1;
    drive(4'h1, 4'h6, 64'h88, 64'h0, 4'h9, F);
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall.dstE", 64'(dstE), 64'h2);
    end
    W_stall = 1'b0; W_bubble = 1'b1;
    cycle("bubble");
    chk("bubble.dstE", 64'(dstE), 64'hF);
    W_bubble = 1'b0;
    cycle("ld9");
    W_stall = 1'b1; W_bubble = 1'b1;
    cycle("stallbub");
    chk("stallbub.dstE", 64'(dstE), 64'h9);
    W_stall = 1'b0; W_bubble = 1'b0;

    // 5: halt is sticky and later instructions are ignored
    drive(4'h2, 4'h0, 64'h55, 64'h0, 4'h5, F);
    cycle("halt");
    chk("halt.dstE", 64'(dstE), 64'hF);
    chk("halt.cpu_stat", 64'(cpu_stat), 64'h2);
    drive(4'h1, 4'h3, 64'h66, 64'h0, 4'h6, F);
    cycle("halt1");
    chk("halt1.halted", 64'(halted), 64'h1);
    cycle("halt2");
    chk("halt2.dstE", 64'(dstE), 64'hF);
    chk("halt2.W_stat", 64'(W_stat), 64'h2);

    // 6: address fault, then reset resumes execution
    asyncReset("rst6");
    drive(4'h3, 4'h5, 64'h0, 64'h99, F, 4'h7);
    cycle("sadr");
    chk("sadr.dstM", 64'(dstM), 64'hF);
    chk("sadr.cpu_stat", 64'(cpu_stat), 64'h3);
    cycle("sadr1");
    asyncReset("rst6b");
    chk("rst6b.cpu_stat", 64'(cpu_stat), 64'h1);
    drive(4'h1, 4'h3, 64'h5, 64'h0, 4'h6, F);
    cycle("resume");
    chk("resume.dstE", 64'(dstE), 64'h6);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [3:0] st, de, dm;
      st = ($urandom_range(19, 0) == 0) ? 4'($urandom_range(4, 2)) : 4'h1;
      de = 4'($urandom_range(15, 0));
      dm = ($urandom_range(3, 0) == 0) ? de : 4'($urandom_range(15, 0));
      drive(st, 4'($urandom_range(11, 0)), {$urandom, $urandom}, {$urandom, $urandom}, de, dm);
      W_stall  = ($urandom_range(4, 0) == 0);
      W_bubble = ($urandom_range(4, 0) == 0);
      rst_n    = ($urandom_range(29, 0) != 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
